whitening_sample_projector: RTL and testbench



---
 rtl/whitening_sample_projector_pkg.sv | 39 +++
 rtl/whitening_sample_projector_if.sv | 35 +++
 rtl/whitening_sample_projector_mac_lane.sv | 46 ++++
 rtl/whitening_sample_projector.sv | 125 ++++++++++++
 tb/tb_whitening_sample_projector.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/whitening_sample_projector_pkg.sv
// Shared widths, FSM state type and the saturating rescale used by every MAC lane.
// Build option WSP_ROUND_EN: round half up before the rescale instead of truncating.
package whiten_pkg;
    localparam int DW   = 26;
    localparam int FRAC = 23;
    localparam int CNTW = 16;
    localparam int ACCW = 2 * DW + 2;
    localparam int N_CH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } wsp_state_e;

    localparam logic signed [ACCW-1:0] Z_MAX = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] Z_MIN = -Z_MAX - ACCW'(1);
`ifdef WSP_ROUND_EN
    localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(64'sd1 <<< (FRAC - 1));
`endif

    // Q-format rescale of a full accumulator back to a DW-bit word, clamped to range.
    function automatic logic signed [DW-1:0] sat_shift(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] adj;
        logic signed [ACCW-1:0] shifted;
`ifdef WSP_ROUND_EN
        adj = acc + RND_HALF;
`else
        adj = acc;
`endif
        shifted = adj >>> FRAC;
        if (shifted > Z_MAX)
            return Z_MAX[DW-1:0];
        else if (shifted < Z_MIN)
            return Z_MIN[DW-1:0];
        else
            return shifted[DW-1:0];
    endfunction
endpackage

// File: rtl/whitening_sample_projector_if.sv
// Sample-in / vector-out handshake bundle plus matrix load and status for the projector.
interface whitening_sample_projector_if;
    import whiten_pkg::*;

    logic                 En_WSP;
    logic                 Ld_V;
    logic signed [DW-1:0] V11, V12, V13, V14;
    logic signed [DW-1:0] V21, V22, V23, V24;
    logic signed [DW-1:0] V31, V32, V33, V34;
    logic signed [DW-1:0] V41, V42, V43, V44;
    logic signed [DW-1:0] X1, X2, X3, X4;
    logic                 x_valid;
    logic                 x_ready;
    logic signed [DW-1:0] Z1, Z2, Z3, Z4;
    logic                 z_valid;
    logic                 z_ready;
    logic                 V_loaded;
    logic [CNTW-1:0]      z_cnt;

    modport master (
        output En_WSP, Ld_V,
        output V11, V12, V13, V14, V21, V22, V23, V24,
        output V31, V32, V33, V34, V41, V42, V43, V44,
        output X1, X2, X3, X4, x_valid, z_ready,
        input  x_ready, Z1, Z2, Z3, Z4, z_valid, V_loaded, z_cnt
    );

    modport slave (
        input  En_WSP, Ld_V,
        input  V11, V12, V13, V14, V21, V22, V23, V24,
        input  V31, V32, V33, V34, V41, V42, V43, V44,
        input  X1, X2, X3, X4, x_valid, z_ready,
        output x_ready, Z1, Z2, Z3, Z4, z_valid, V_loaded, z_cnt
    );
endinterface

// File: rtl/whitening_sample_projector_mac_lane.sv
// One matrix row: accumulates V[i][k]*x[k] over four columns, then rescales into Z_i.
module whiten_mac_lane
    import whiten_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 mac_i,
    input  logic                 last_i,
    input  logic signed [DW-1:0] v_i,
    input  logic signed [DW-1:0] x_i,
    output logic signed [DW-1:0] z_o
);
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [DW-1:0]   z_q, z_d;

    assign prod = v_i * x_i;
    assign sum  = acc_q + ACCW'(prod);

    // The final column's product goes straight into the rescale so Z lands on the k=3 edge.
    always_comb begin
        acc_d = acc_q;
        z_d   = z_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (mac_i) begin
            acc_d = sum;
            if (last_i)
                z_d = sat_shift(sum);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            z_q   <= '0;
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
        end
    end

    assign z_o = z_q;
endmodule

// File: rtl/whitening_sample_projector.sv
// Applies a captured 4x4 whitening matrix to each accepted sample, one column per cycle.
// Build option WSP_ROUND_EN selects round-half-up rescaling in the lanes.
module whitening_sample_projector
    import whiten_pkg::*;
(
    input  logic CLK_WSP,
    input  logic RSTN_WSP,
    whitening_sample_projector_if.slave bus
);
    wsp_state_e           state_q, state_d;
    logic [1:0]           k_q, k_d;
    logic signed [DW-1:0] v_q [N_CH][N_CH];
    logic signed [DW-1:0] v_d [N_CH][N_CH];
    logic signed [DW-1:0] x_q [N_CH];
    logic signed [DW-1:0] x_d [N_CH];
    logic                 v_loaded_q, v_loaded_d;
    logic                 z_valid_q, z_valid_d;
    logic [CNTW-1:0]      z_cnt_q, z_cnt_d;

    logic signed [DW-1:0] v_in [N_CH][N_CH];
    logic signed [DW-1:0] x_in [N_CH];
    logic signed [DW-1:0] z_lane [N_CH];
    logic                 x_ready_c;
    logic                 acc_clr;
    logic                 mac_en;

    assign v_in = '{'{bus.V11, bus.V12, bus.V13, bus.V14},
                    '{bus.V21, bus.V22, bus.V23, bus.V24},
                    '{bus.V31, bus.V32, bus.V33, bus.V34},
                    '{bus.V41, bus.V42, bus.V43, bus.V44}};
    assign x_in = '{bus.X1, bus.X2, bus.X3, bus.X4};

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        v_d        = v_q;
        x_d        = x_q;
        v_loaded_d = v_loaded_q;
        z_valid_d  = z_valid_q;
        z_cnt_d    = z_cnt_q;
        x_ready_c  = 1'b0;
        acc_clr    = 1'b0;
        mac_en     = 1'b0;
        // Disable aborts any sample in flight but keeps the matrix and the output count.
        if (!bus.En_WSP) begin
            state_d   = IDLE;
            k_d       = '0;
            z_valid_d = 1'b0;
            acc_clr   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    x_ready_c = v_loaded_q & ~bus.Ld_V;
                    if (bus.Ld_V) begin
                        v_d        = v_in;
                        v_loaded_d = 1'b1;
                    end else if (x_ready_c && bus.x_valid) begin
                        x_d     = x_in;
                        k_d     = '0;
                        acc_clr = 1'b1;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    mac_en = 1'b1;
                    k_d    = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        z_valid_d = 1'b1;
                        state_d   = OUT;
                    end
                end
                OUT: begin
                    if (bus.z_ready) begin
                        z_valid_d = 1'b0;
                        z_cnt_d   = z_cnt_q + 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_WSP or negedge RSTN_WSP) begin
        if (!RSTN_WSP) begin
            state_q    <= IDLE;
            k_q        <= '0;
            v_q        <= '{default: '{default: '0}};
            x_q        <= '{default: '0};
            v_loaded_q <= 1'b0;
            z_valid_q  <= 1'b0;
            z_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            v_q        <= v_d;
            x_q        <= x_d;
            v_loaded_q <= v_loaded_d;
            z_valid_q  <= z_valid_d;
            z_cnt_q    <= z_cnt_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        whiten_mac_lane u_lane (
            .clk_i  (CLK_WSP),
            .rst_ni (RSTN_WSP),
            .clr_i  (acc_clr),
            .mac_i  (mac_en),
            .last_i (k_q == 2'd3),
            .v_i    (v_q[i][k_q]),
            .x_i    (x_q[k_q]),
            .z_o    (z_lane[i])
        );
    end

    assign bus.x_ready  = x_ready_c;
    assign bus.z_valid  = z_valid_q;
    assign bus.V_loaded = v_loaded_q;
    assign bus.z_cnt    = z_cnt_q;
    assign bus.Z1       = z_lane[0];
    assign bus.Z2       = z_lane[1];
    assign bus.Z3       = z_lane[2];
    assign bus.Z4       = z_lane[3];
endmodule

// File: tb/tb_whitening_sample_projector.sv
// Directed vector bench for the whitening sample projector (honours WSP_ROUND_EN).
module tb_whitening_sample_projector;
    import whiten_pkg::*;

    localparam logic [DW-1:0] ZERO   = 26'h0000000;
    localparam logic [DW-1:0] ONE    = 26'h0800000;
    localparam logic [DW-1:0] HALF   = 26'h0400000;
    localparam logic [DW-1:0] QTR    = 26'h0200000;
    localparam logic [DW-1:0] EIGHTH = 26'h0100000;
    localparam logic [DW-1:0] P75    = 26'h0600000;
    localparam logic [DW-1:0] NHALF  = 26'h3C00000;
    localparam logic [DW-1:0] NONE   = 26'h3800000;
    localparam logic [DW-1:0] TWO    = 26'h1000000;
    localparam logic [DW-1:0] NTWO   = 26'h3000000;
    localparam logic [DW-1:0] THREE  = 26'h1800000;
    localparam logic [DW-1:0] NTHREE = 26'h2800000;
    localparam logic [DW-1:0] MAXP   = 26'h1FFFFFF;
    localparam logic [DW-1:0] MINN   = 26'h2000000;
    localparam logic [DW-1:0] LSB    = 26'h0000001;
    localparam logic [DW-1:0] NLSB   = 26'h3FFFFFF;
`ifdef WSP_ROUND_EN
    localparam logic [DW-1:0] HZ1 = LSB;
    localparam logic [DW-1:0] HZ2 = ZERO;
`else
    localparam logic [DW-1:0] HZ1 = ZERO;
    localparam logic [DW-1:0] HZ2 = NLSB;
`endif

    typedef struct packed {
        logic [3:0][DW-1:0] r1, r2, r3, r4, x, z;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    vec_t vecs [5];

    whitening_sample_projector_if bus();

    whitening_sample_projector dut (
        .CLK_WSP  (clk),
        .RSTN_WSP (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0][DW-1:0] p4(input logic [DW-1:0] a, b, c, d);
        logic [3:0][DW-1:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.x_ready && bus.x_valid) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Loads V with x already offered, then runs to z_valid and checks latency and Z.
    task automatic start_vec(input vec_t t, input string nm);
        bit ok;
        @(posedge clk); #1;
        bus.V11 = t.r1[0]; bus.V12 = t.r1[1]; bus.V13 = t.r1[2]; bus.V14 = t.r1[3];
        bus.V21 = t.r2[0]; bus.V22 = t.r2[1]; bus.V23 = t.r2[2]; bus.V24 = t.r2[3];
        bus.V31 = t.r3[0]; bus.V32 = t.r3[1]; bus.V33 = t.r3[2]; bus.V34 = t.r3[3];
        bus.V41 = t.r4[0]; bus.V42 = t.r4[1]; bus.V43 = t.r4[2]; bus.V44 = t.r4[3];
        bus.X1 = t.x[0]; bus.X2 = t.x[1]; bus.X3 = t.x[2]; bus.X4 = t.x[3];
        bus.Ld_V = 1'b1;
        bus.x_valid = 1'b1;
        @(negedge clk);
        check({nm, "_ldv_priority_x_ready"}, DW'(bus.x_ready), ZERO);
        @(posedge clk); #1;
        bus.Ld_V = 1'b0;
        wait_accept(ok);
        check({nm, "_accept"}, DW'(ok), LSB);
        bus.x_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({nm, "_z_valid_early"}, DW'(bus.z_valid), ZERO);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_z_valid_n4"}, DW'(bus.z_valid), LSB);
        check({nm, "_Z1"}, bus.Z1, t.z[0]);
        check({nm, "_Z2"}, bus.Z2, t.z[1]);
        check({nm, "_Z3"}, bus.Z3, t.z[2]);
        check({nm, "_Z4"}, bus.Z4, t.z[3]);
    endtask

    task automatic finish_vec(input string nm);
        bus.z_ready = 1'b1;
        @(posedge clk); #1;
        bus.z_ready = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check({nm, "_z_valid_drop"}, DW'(bus.z_valid), ZERO);
        check({nm, "_z_cnt"}, DW'(bus.z_cnt), DW'(exp_cnt));
    endtask

    initial begin
        int bad;
        vecs[0] = '{r1: p4(ONE, ZERO, ZERO, ZERO), r2: p4(ZERO, ONE, ZERO, ZERO),
                    r3: p4(ZERO, ZERO, ONE, ZERO), r4: p4(ZERO, ZERO, ZERO, ONE),
                    x: p4(ONE, NHALF, QTR, ZERO), z: p4(ONE, NHALF, QTR, ZERO)};
        vecs[1] = '{r1: p4(THREE, THREE, THREE, THREE), r2: p4(ZERO, ONE, ZERO, ZERO),
                    r3: p4(ZERO, ZERO, ONE, ZERO), r4: p4(ZERO, ZERO, ZERO, ONE),
                    x: p4(THREE, THREE, THREE, THREE), z: p4(MAXP, THREE, THREE, THREE)};
        vecs[2] = '{r1: p4(NTHREE, NTHREE, NTHREE, NTHREE), r2: p4(ZERO, ONE, ZERO, ZERO),
                    r3: p4(ZERO, ZERO, ONE, ZERO), r4: p4(ZERO, ZERO, ZERO, ONE),
                    x: p4(THREE, THREE, THREE, THREE), z: p4(MINN, THREE, THREE, THREE)};
        vecs[3] = '{r1: p4(ONE, ONE, ZERO, ZERO), r2: p4(ZERO, ZERO, ZERO, NONE),
                    r3: p4(HALF, ZERO, ZERO, ZERO), r4: p4(ZERO, ZERO, TWO, ZERO),
                    x: p4(QTR, HALF, NONE, ONE), z: p4(P75, NONE, EIGHTH, NTWO)};
        vecs[4] = '{r1: p4(HALF, ZERO, ZERO, ZERO), r2: p4(ZERO, HALF, ZERO, ZERO),
                    r3: p4(ZERO, ZERO, HALF, ZERO), r4: p4(ZERO, ZERO, ZERO, HALF),
                    x: p4(LSB, NLSB, ZERO, ZERO), z: p4(HZ1, HZ2, ZERO, ZERO)};

        rst_n = 1'b0;
        bus.En_WSP = 1'b1; bus.Ld_V = 1'b0; bus.x_valid = 1'b0; bus.z_ready = 1'b0;
        bus.V11 = '0; bus.V12 = '0; bus.V13 = '0; bus.V14 = '0;
        bus.V21 = '0; bus.V22 = '0; bus.V23 = '0; bus.V24 = '0;
        bus.V31 = '0; bus.V32 = '0; bus.V33 = '0; bus.V34 = '0;
        bus.V41 = '0; bus.V42 = '0; bus.V43 = '0; bus.V44 = '0;
        bus.X1 = '0; bus.X2 = '0; bus.X3 = '0; bus.X4 = '0;
        #23 rst_n = 1'b1;

        @(negedge clk);
        check("rst_z_valid", DW'(bus.z_valid), ZERO);
        check("rst_V_loaded", DW'(bus.V_loaded), ZERO);
        check("rst_z_cnt", DW'(bus.z_cnt), ZERO);
        check("rst_x_ready", DW'(bus.x_ready), ZERO);
        check("rst_Z1", bus.Z1, ZERO);
        check("rst_Z4", bus.Z4, ZERO);

        // No matrix yet: offered samples must be refused.
        @(posedge clk); #1;
        bus.x_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.x_ready || bus.z_valid) bad++;
        end
        check("noV_ready_or_valid_cycles", DW'(bad), ZERO);
        @(posedge clk); #1;
        bus.x_valid = 1'b0;
        bus.V11 = ONE; bus.V22 = ONE; bus.V33 = ONE; bus.V44 = ONE;
        bus.Ld_V = 1'b1;
        @(posedge clk); #1;
        bus.Ld_V = 1'b0;
        @(negedge clk);
        check("ldv_V_loaded", DW'(bus.V_loaded), LSB);
        check("ldv_x_ready", DW'(bus.x_ready), LSB);

        for (int i = 0; i < 5; i++) begin
            start_vec(vecs[i], $sformatf("vec%0d", i));
            finish_vec($sformatf("vec%0d", i));
        end

        // Backpressure in OUT: Z held, sample refused.
        start_vec(vecs[3], "stall");
        bus.x_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.z_valid || bus.x_ready || bus.Z1 !== vecs[3].z[0] || bus.Z2 !== vecs[3].z[1]
                || bus.Z3 !== vecs[3].z[2] || bus.Z4 !== vecs[3].z[3]) bad++;
        end
        check("stall_hold_cycles", DW'(bad), ZERO);
        bus.x_valid = 1'b0;
        finish_vec("stall");
        repeat (3) @(negedge clk);
        check("stall_z_cnt_once", DW'(bus.z_cnt), DW'(exp_cnt));

        // Disable while k=2 is being processed.
        begin
            bit ok;
            @(posedge clk); #1;
            bus.X1 = ONE; bus.X2 = ONE; bus.X3 = ONE; bus.X4 = ONE;
            bus.x_valid = 1'b1;
            wait_accept(ok);
            check("en_accept", DW'(ok), LSB);
            bus.x_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1 bus.En_WSP = 1'b0;
            @(negedge clk);
            check("en_low_x_ready", DW'(bus.x_ready), ZERO);
            @(posedge clk); #1;
            bus.En_WSP = 1'b1;
            @(negedge clk);
            check("en_idle_x_ready", DW'(bus.x_ready), LSB);
            check("en_V_loaded", DW'(bus.V_loaded), LSB);
            bad = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.z_valid) bad++;
            end
            check("en_no_z_valid", DW'(bad), ZERO);
            check("en_z_cnt", DW'(bus.z_cnt), DW'(exp_cnt));
        end

        // Asynchronous reset while holding a result.
        start_vec(vecs[0], "rstout");
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("rstout_z_valid", DW'(bus.z_valid), ZERO);
        check("rstout_Z1", bus.Z1, ZERO);
        check("rstout_Z2", bus.Z2, ZERO);
        check("rstout_V_loaded", DW'(bus.V_loaded), ZERO);
        check("rstout_z_cnt", DW'(bus.z_cnt), DW'(exp_cnt));
        check("rstout_x_ready", DW'(bus.x_ready), ZERO);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
